// File: rtl/result_box_emitter_if.sv
// Box stream from the emitter to the overlay/display stage.
// A box is accepted on any cycle with o_box_valid && box_ready.
interface result_box_emitter_if #(
  parameter int DW = 12,
  parameter int SW = 3
);
  logic          o_box_valid;
  logic          box_ready;
  logic [DW-1:0] o_box_x0;
  logic [DW-1:0] o_box_y0;
  logic [DW-1:0] o_box_x1;
  logic [DW-1:0] o_box_y1;
  logic [SW-1:0] o_box_scale;

  modport master (
    output o_box_valid, o_box_x0, o_box_y0, o_box_x1, o_box_y1, o_box_scale,
    input  box_ready
  );

  modport slave (
    input  o_box_valid, o_box_x0, o_box_y0, o_box_x1, o_box_y1, o_box_scale,
    output box_ready
  );
endinterface

// File: rtl/result_box_emitter.sv
// Drains (x, y, mask) records from the result FIFO and emits one clipped box per set mask bit.
// First box 8 cycles after start; a held box (box_ready low) stalls further FIFO reads.
module result_box_emitter #(
  parameter int DATA_WIDTH_12 = 12,
  parameter int NUM_RESIZE    = 5,
  parameter int BASE_WINDOW   = 24,
  parameter int WINDOW_STEP   = 6,
  parameter int IMAGE_WIDTH   = 320,
  parameter int IMAGE_HEIGHT  = 240
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [DATA_WIDTH_12-1:0] result_count,
  output logic                     o_read_req,
  input  logic [DATA_WIDTH_12-1:0] data_in,
  result_box_emitter_if.master     box,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error
);

  localparam int DW = DATA_WIDTH_12;
  localparam logic [DW:0] XMAX = (DW+1)'(IMAGE_WIDTH - 1);
  localparam logic [DW:0] YMAX = (DW+1)'(IMAGE_HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_EXPAND, S_EMIT, S_DONE
  } state_t;

  state_t                r_state, w_next;
  logic [DW-1:0]         r_nrec;
  logic [1:0]            r_widx;
  logic [DW-1:0]         r_ori_x, r_ori_y;
  logic [NUM_RESIZE-1:0] r_mask;
  logic                  r_error;
  logic [DW-1:0]         r_box_x0, r_box_y0, r_box_x1, r_box_y1;
  logic [2:0]            r_box_k;

  logic [2:0]            w_k;
  logic [DW:0]           w_size, w_x_sum, w_y_sum;
  logic [DW-1:0]         w_x1, w_y1;
  logic                  w_mask_any;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    o_read_req = 1'b0;
    o_busy     = 1'b1;
    o_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (start) w_next = (result_count < DW'(3)) ? S_DONE : S_REQ;
      end
      S_REQ: begin
        o_read_req = 1'b1;
        w_next     = S_WAIT;
      end
      S_WAIT:   w_next = (r_widx == 2'd2) ? S_EXPAND : S_REQ;
      S_EXPAND: begin
        if (w_mask_any)               w_next = S_EMIT;
        else if (r_nrec == DW'(1))    w_next = S_DONE;
        else                          w_next = S_REQ;
      end
      S_EMIT:   if (box.box_ready) w_next = S_EXPAND;
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Lowest set bit wins: scan from the top so the last hit is the lowest index.
  always_comb begin
    w_k = 3'd0;
    for (int i = NUM_RESIZE - 1; i >= 0; i--) begin
      if (r_mask[i]) w_k = 3'(i);
    end
  end

  assign w_mask_any = |r_mask;
  assign w_size     = (DW+1)'(BASE_WINDOW + WINDOW_STEP * int'(w_k));
  assign w_x_sum    = {1'b0, r_ori_x} + w_size - (DW+1)'(1);
  assign w_y_sum    = {1'b0, r_ori_y} + w_size - (DW+1)'(1);
  assign w_x1       = (w_x_sum > XMAX) ? XMAX[DW-1:0] : w_x_sum[DW-1:0];
  assign w_y1       = (w_y_sum > YMAX) ? YMAX[DW-1:0] : w_y_sum[DW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_nrec   <= '0;
      r_widx   <= '0;
      r_ori_x  <= '0;
      r_ori_y  <= '0;
      r_mask   <= '0;
      r_error  <= 1'b0;
      r_box_x0 <= '0;
      r_box_y0 <= '0;
      r_box_x1 <= '0;
      r_box_y1 <= '0;
      r_box_k  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_nrec  <= result_count / DW'(3);
            r_error <= (result_count % DW'(3)) != '0;
            r_widx  <= '0;
          end
        end
        S_WAIT: begin
          case (r_widx)
            2'd0:    r_ori_x <= data_in;
            2'd1:    r_ori_y <= data_in;
            default: r_mask  <= data_in[NUM_RESIZE-1:0];
          endcase
          r_widx <= (r_widx == 2'd2) ? 2'd0 : r_widx + 2'd1;
        end
        S_EXPAND: begin
          if (w_mask_any) begin
            r_box_x0 <= r_ori_x;
            r_box_y0 <= r_ori_y;
            r_box_x1 <= w_x1;
            r_box_y1 <= w_y1;
            r_box_k  <= w_k;
          end else begin
            r_nrec <= r_nrec - DW'(1);
          end
        end
        // The mask is untouched since EXPAND, so its lowest set bit is the box just sent.
        S_EMIT: if (box.box_ready) r_mask <= r_mask & (r_mask - NUM_RESIZE'(1));
        default: ;
      endcase
    end
  end

  assign box.o_box_valid = (r_state == S_EMIT);
  assign box.o_box_x0    = r_box_x0;
  assign box.o_box_y0    = r_box_y0;
  assign box.o_box_x1    = r_box_x1;
  assign box.o_box_y1    = r_box_y1;
  assign box.o_box_scale = r_box_k;
  assign o_error         = r_error;

endmodule

// File: tb/tb_result_box_emitter.sv
// Bench for result_box_emitter: FIFO responder, box collector and a record-level box model.
module tb_result_box_emitter;

  typedef struct packed {
    logic [11:0] x0;
    logic [11:0] y0;
    logic [11:0] x1;
    logic [11:0] y1;
    logic [2:0]  k;
  } box_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] result_count = '0;
  logic [11:0] data_in = '0;
  logic        o_read_req, o_busy, o_done, o_error;

  result_box_emitter_if bif ();

  result_box_emitter dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .result_count (result_count),
    .o_read_req   (o_read_req),
    .data_in      (data_in),
    .box          (bif.master),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          reads = 0;
  int          done_cnt = 0;
  int          done_rel = -1;
  int          stall_budget = 0;
  bit          rand_ready = 0;
  logic [11:0] fifo_q[$];
  int          read_rel[$];
  int          acc_rel[$];
  box_t        got_q[$];
  box_t        exp_q[$];
  box_t        held;
  bit          held_vld = 0;

  always @(posedge clk) cyc++;

  function automatic box_t cur_box();
    box_t b;
    b.x0 = bif.o_box_x0; b.y0 = bif.o_box_y0;
    b.x1 = bif.o_box_x1; b.y1 = bif.o_box_y1;
    b.k  = bif.o_box_scale;
    return b;
  endfunction

  // FIFO responder and box collector; inputs change only on the falling edge.
  always @(negedge clk) begin
    if (bif.o_box_valid && stall_budget > 0) begin
      bif.box_ready = 1'b0;
      stall_budget--;
    end else if (rand_ready) begin
      bif.box_ready = 1'($urandom_range(0, 1));
    end else begin
      bif.box_ready = 1'b1;
    end
    if (!reset) begin
      if (held_vld && bif.o_box_valid) begin
        n_chk++;
        if (cur_box() !== held) begin
          n_fail++;
          $display("FAIL box_hold: got %h required %h", cur_box(), held);
        end
      end
      if (bif.o_box_valid) begin
        n_chk++;
        if (o_read_req !== 1'b0) begin
          n_fail++;
          $display("FAIL read_during_box: read_req %b required 0", o_read_req);
        end
      end
      if (bif.o_box_valid && bif.box_ready) begin
        got_q.push_back(cur_box());
        acc_rel.push_back(cyc - start_cyc);
      end
      held_vld = bif.o_box_valid && !bif.box_ready;
      held     = cur_box();
      if (o_read_req) begin
        reads++;
        read_rel.push_back(cyc - start_cyc);
        data_in = (fifo_q.size() > 0) ? fifo_q.pop_front() : 12'h000;
      end
      if (o_done) begin
        done_cnt++;
        done_rel = cyc - start_cyc;
      end
    end else begin
      held_vld = 0;
    end
  end

  // Reference: every complete record yields a box per set mask bit, smallest level first.
  function automatic void build_expect(int cnt);
    exp_q.delete();
    for (int r = 0; r < cnt / 3; r++) begin
      int x = int'(fifo_q[3*r]);
      int y = int'(fifo_q[3*r+1]);
      int m = int'(fifo_q[3*r+2]) % 32;
      for (int k = 0; k < 5; k++) begin
        if (((m >> k) & 1) == 1) begin
          int sz = 24 + 6 * k;
          box_t b;
          b.x0 = 12'(x); b.y0 = 12'(y);
          b.x1 = 12'((x + sz - 1 > 319) ? 319 : x + sz - 1);
          b.y1 = 12'((y + sz - 1 > 239) ? 239 : y + sz - 1);
          b.k  = 3'(k);
          exp_q.push_back(b);
        end
      end
    end
  endfunction

  task automatic clear_obs();
    got_q.delete(); acc_rel.delete(); read_rel.delete();
    reads = 0; done_cnt = 0; done_rel = -1;
  endtask

  task automatic pulse_start(input logic [11:0] cnt);
    @(negedge clk);
    result_count = cnt;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic recover();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    stall_budget = 0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (o_done !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (t >= 3000) begin
      n_fail++;
      $display("FAIL %s_timeout: no o_done after %0d cycles", name, t);
      recover();
    end
    @(negedge clk);
  endtask

  task automatic drain_and_check(input string name, input int cnt);
    build_expect(cnt);
    clear_obs();
    pulse_start(12'(cnt));
    wait_done(name);
    n_chk++;
    if (reads !== 3 * (cnt / 3)) begin
      n_fail++; $display("FAIL %s_reads: got %0d required %0d", name, reads, 3 * (cnt / 3));
    end
    n_chk++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL %s_nbox: got %0d required %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL %s_box%0d: got %h required %h", name, i, got_q[i], exp_q[i]);
      end
    end
    n_chk++;
    if (done_cnt !== 1 || o_done !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done: pulses %0d done %b busy %b required 1/0/0", name, done_cnt, o_done, o_busy);
    end
    n_chk++;
    if (o_error !== ((cnt % 3) != 0)) begin
      n_fail++; $display("FAIL %s_error: got %b required %b", name, o_error, (cnt % 3) != 0);
    end
  endtask

  task automatic push_rec(input int x, input int y, input int m);
    fifo_q.push_back(12'(x)); fifo_q.push_back(12'(y)); fifo_q.push_back(12'(m));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({o_read_req, o_busy, o_done, o_error, bif.o_box_valid} !== 5'b0 || cur_box() !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ctl %b box %h required 0", {o_read_req, o_busy, o_done, o_error, bif.o_box_valid}, cur_box());
    end
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if (o_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: busy %b required 0", o_busy);
    end
  endtask

  task automatic test_basic();
    fifo_q.delete();
    push_rec(100, 50, 5);
    drain_and_check("basic", 3);
    n_chk++;
    if (read_rel.size() != 3 || read_rel[0] != 1 || read_rel[1] != 3 || read_rel[2] != 5) begin
      n_fail++; $display("FAIL basic_read_timing: got %p required 1,3,5", read_rel);
    end
    n_chk++;
    if (acc_rel.size() != 2 || acc_rel[0] != 8 || acc_rel[1] != 10) begin
      n_fail++; $display("FAIL basic_box_timing: got %p required 8,10", acc_rel);
    end
  endtask

  task automatic test_clip();
    fifo_q.delete();
    push_rec(300, 230, 16);
    drain_and_check("clip", 3);
  endtask

  task automatic test_backpressure();
    fifo_q.delete();
    push_rec(100, 50, 5);
    stall_budget = 10;
    drain_and_check("bp", 3);
    n_chk++;
    if (acc_rel.size() != 2 || acc_rel[0] != 18 || acc_rel[1] != 20) begin
      n_fail++; $display("FAIL bp_box_timing: got %p required 18,20", acc_rel);
    end
  endtask

  task automatic test_count_edges();
    fifo_q.delete();
    drain_and_check("cnt0", 0);
    n_chk++;
    if (done_rel != 1) begin
      n_fail++; $display("FAIL cnt0_done_cycle: got %0d required 1", done_rel);
    end
    fifo_q.delete();
    push_rec(7, 8, 3); push_rec(200, 100, 24); fifo_q.push_back(12'hABC);
    drain_and_check("cnt7", 7);
    fifo_q.delete();
    push_rec(1, 2, 1);
    drain_and_check("cnt3_clr", 3);
  endtask

  task automatic test_zero_mask();
    fifo_q.delete();
    push_rec(10, 10, 0); push_rec(20, 20, 1);
    drain_and_check("zmask", 6);
  endtask

  task automatic test_reset_mid_emit();
    int t = 0;
    fifo_q.delete();
    push_rec(100, 50, 5);
    clear_obs();
    stall_budget = 1000;
    pulse_start(12'd3);
    while (bif.o_box_valid !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (t >= 100) begin
      n_fail++; $display("FAIL rst_emit_reach: no o_box_valid after %0d cycles", t);
    end
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({o_read_req, o_busy, o_done, o_error, bif.o_box_valid} !== 5'b0 || cur_box() !== '0) begin
      n_fail++;
      $display("FAIL rst_emit_outputs: ctl %b box %h required 0", {o_read_req, o_busy, o_done, o_error, bif.o_box_valid}, cur_box());
    end
    @(negedge clk);
    reset = 1'b0;
    stall_budget = 0;
    done_cnt = 0;
    reads = 0;
    repeat (20) @(negedge clk);
    n_chk++;
    if (reads != 0 || done_cnt != 0 || o_busy !== 1'b0 || got_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_emit_quiet: reads %0d dones %0d busy %b boxes %0d required 0", reads, done_cnt, o_busy, got_q.size());
    end
  endtask

  task automatic test_start_while_busy();
    fifo_q.delete();
    push_rec(100, 50, 5);
    build_expect(3);
    push_rec(40, 40, 31);
    clear_obs();
    pulse_start(12'd3);
    repeat (3) @(negedge clk);
    result_count = 12'd6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start");
    repeat (20) @(negedge clk);
    n_chk++;
    if (reads != 3 || done_cnt != 1 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_start_ignored: reads %0d dones %0d busy %b required 3/1/0", reads, done_cnt, o_busy);
    end
    n_chk++;
    if (got_q.size() != 2 || (got_q.size() == 2 && (got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]))) begin
      n_fail++; $display("FAIL busy_start_boxes: got %0d boxes required 2 matching", got_q.size());
    end
  endtask

  task automatic test_random();
    rand_ready = 1;
    for (int run = 0; run < 20; run++) begin
      int cnt = $urandom_range(0, 13);
      fifo_q.delete();
      for (int w = 0; w < cnt; w++) begin
        case (w % 3)
          0:       fifo_q.push_back(12'($urandom_range(0, 400)));
          1:       fifo_q.push_back(12'($urandom_range(0, 300)));
          default: fifo_q.push_back(12'($urandom));
        endcase
      end
      drain_and_check("rand", cnt);
    end
    rand_ready = 0;
  endtask

  initial begin
    bif.box_ready = 1'b1;
    test_reset();
    test_basic();
    test_clip();
    test_backpressure();
    test_count_edges();
    test_zero_mask();
    test_reset_mid_emit();
    test_start_while_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
